mc_ctrl_fsm: RTL and testbench

- Multicycle control sequencer for the RV32I core.
- Walks each instruction through fetch, decode, execute, memory and writeback states, and drives the shared datapath select/enable lines cycle by cycle: one ALU, one unified memory port, IR and PC enables.
- Issues a req/ready handshake to the unified memory port.
- Keeps a retired-instruction counter.

---
 rtl/mc_ctrl_fsm.sv | 169 ++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle RV32I control sequencer with memory handshake and instret counter.
// Define MC_ILLEGAL_TRAP_EN to trap on illegal opcodes instead of treating them as NOPs.
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             B_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             pc_write,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUop,
    output logic [2:0]       ImmSrc,
    output logic             Branch,
    output logic [CNT_W-1:0] instret,
    output logic             trap
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam state_t ILL_NXT = TRAP;
`else
    localparam state_t ILL_NXT = FETCH;
`endif

    state_t state, nxt;
    logic   pc_update;
    logic [2:0] imm_dec;

    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:    nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = MEMADR;
                    OP_R:              nxt = EXECR;
                    OP_I:              nxt = EXECI;
                    OP_B:              nxt = BRANCH;
                    OP_JAL:            nxt = JAL;
                    OP_JALR:           nxt = JALR;
                    OP_LUI:            nxt = LUI;
                    OP_AUIPC:          nxt = AUIPC;
                    default:           nxt = ILL_NXT;
                endcase
            end
            MEMADR:   nxt = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI, LUI, AUIPC, JAL: nxt = ALUWB;
            JALR:     nxt = JAL;
            TRAP:     nxt = TRAP;
            default:  nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            state <= nxt;
            if (nxt == FETCH && state != FETCH)
                instret <= instret + CNT_W'(1);
        end
    end

    assign imm_dec = (opcode == OP_STORE)                     ? 3'b001 :
                     (opcode == OP_B)                         ? 3'b010 :
                     (opcode == OP_JAL)                       ? 3'b011 :
                     (opcode == OP_LUI || opcode == OP_AUIPC) ? 3'b100 : 3'b000;

    always_comb begin
        mem_req   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUop     = 2'b00;
        ImmSrc    = 3'b000;
        Branch    = 1'b0;
        pc_update = 1'b0;
        if (!reset) begin
            ImmSrc = (state == TRAP) ? 3'b000 : imm_dec;
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    pc_update = mem_ready;
                end
                DECODE, AUIPC: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                MEMADR, EXECI, JALR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUop   = (state == EXECI) ? 2'b10 : 2'b00;
                end
                MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                MEMWRITE: begin
                    mem_req  = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                EXECR: begin
                    ALUSrcA = 2'b10;
                    ALUop   = 2'b10;
                end
                ALUWB: RegWrite = 1'b1;
                BRANCH: begin
                    ALUSrcA = 2'b10;
                    ALUop   = 2'b01;
                    Branch  = 1'b1;
                end
                JAL: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    pc_update = 1'b1;
                end
                LUI: begin
                    ALUSrcA = 2'b11;
                    ALUSrcB = 2'b01;
                end
                default: ;
            endcase
        end
        pc_write = pc_update | (Branch & B_taken);
    end

`ifdef MC_ILLEGAL_TRAP_EN
    assign trap = !reset && state == TRAP;
`else
    assign trap = 1'b0;
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed checks of the mc_ctrl_fsm control sequence, handshake and instret.
module tb_mc_ctrl_fsm;
    logic        clk = 1'b0;
    logic        reset, B_taken, mem_ready;
    logic [6:0]  opcode;
    logic        mem_req, AdrSrc, MemWrite, IRWrite, pc_write, RegWrite, Branch, trap;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUop;
    logic [2:0]  ImmSrc;
    logic [31:0] instret, exp_ret;
    logic [18:0] ctl;
    int          n_tests = 0, n_fail = 0;

    // field order: mem_req AdrSrc MemWrite IRWrite pc_write RegWrite ResultSrc ALUSrcA ALUSrcB ALUop ImmSrc Branch trap
    assign ctl = {mem_req, AdrSrc, MemWrite, IRWrite, pc_write, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUop, ImmSrc, Branch, trap};

    mc_ctrl_fsm #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .B_taken(B_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .pc_write(pc_write), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUop(ALUop), .ImmSrc(ImmSrc), .Branch(Branch),
        .instret(instret), .trap(trap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        reset = 1'b1; mem_ready = 1'b1; opcode = 7'b0100011; B_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (ctl !== 19'b0) begin n_fail++; $display("FAIL reset_ctl cyc%0d got %b exp %b", i, ctl, 19'b0); end
        end
        n_tests++;
        if (instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret got %0d exp 0", instret); end
        reset = 1'b0; opcode = 7'b0110011; B_taken = 1'b0;
        #1;
        n_tests++;
        if (ctl !== 19'b1_0_0_1_1_0_10_00_10_00_000_0_0) begin
            n_fail++; $display("FAIL reset_release got %b exp %b", ctl, 19'b1_0_0_1_1_0_10_00_10_00_000_0_0);
        end
        exp_ret = 0;
    endtask

    task automatic test_rtype;
        logic [18:0] e [4];
        e = '{19'b1_0_0_1_1_0_10_00_10_00_000_0_0, 19'b0_0_0_0_0_0_00_01_01_00_000_0_0,
              19'b0_0_0_0_0_0_00_10_00_10_000_0_0, 19'b0_0_0_0_0_1_00_00_00_00_000_0_0};
        opcode = 7'b0110011; mem_ready = 1'b1; B_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (ctl !== e[i]) begin n_fail++; $display("FAIL rtype cyc%0d got %b exp %b", i, ctl, e[i]); end
            @(negedge clk);
        end
        B_taken = 1'b0;
        exp_ret++;
        n_tests++;
        if (instret !== exp_ret) begin n_fail++; $display("FAIL rtype_instret got %0d exp %0d", instret, exp_ret); end
    endtask

    task automatic test_load;
        logic [18:0] e [8];
        logic        mr [8];
        e = '{19'b1_0_0_1_1_0_10_00_10_00_000_0_0, 19'b0_0_0_0_0_0_00_01_01_00_000_0_0,
              19'b0_0_0_0_0_0_00_10_01_00_000_0_0, 19'b1_1_0_0_0_0_00_00_00_00_000_0_0,
              19'b1_1_0_0_0_0_00_00_00_00_000_0_0, 19'b1_1_0_0_0_0_00_00_00_00_000_0_0,
              19'b1_1_0_0_0_0_00_00_00_00_000_0_0, 19'b0_0_0_0_0_1_01_00_00_00_000_0_0};
        mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            n_tests++;
            if (ctl !== e[i]) begin n_fail++; $display("FAIL load cyc%0d got %b exp %b", i, ctl, e[i]); end
            @(negedge clk);
        end
        exp_ret++;
        n_tests++;
        if (instret !== exp_ret) begin n_fail++; $display("FAIL load_instret got %0d exp %0d", instret, exp_ret); end
    endtask

    task automatic test_store;
        logic [18:0] e [5];
        logic        mr [5];
        e = '{19'b1_0_0_0_0_0_10_00_10_00_001_0_0, 19'b1_0_0_1_1_0_10_00_10_00_001_0_0,
              19'b0_0_0_0_0_0_00_01_01_00_001_0_0, 19'b0_0_0_0_0_0_00_10_01_00_001_0_0,
              19'b1_1_1_0_0_0_00_00_00_00_001_0_0};
        mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        opcode = 7'b0100011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            #1;
            n_tests++;
            if (ctl !== e[i]) begin n_fail++; $display("FAIL store cyc%0d got %b exp %b", i, ctl, e[i]); end
            @(negedge clk);
        end
        exp_ret++;
        n_tests++;
        if (instret !== exp_ret) begin n_fail++; $display("FAIL store_instret got %0d exp %0d", instret, exp_ret); end
    endtask

    task automatic test_branch(input logic tk);
        logic [18:0] e [3];
        e = '{19'b1_0_0_1_1_0_10_00_10_00_010_0_0, 19'b0_0_0_0_0_0_00_01_01_00_010_0_0,
              {1'b0, 1'b0, 1'b0, 1'b0, tk, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 1'b1, 1'b0}};
        opcode = 7'b1100011; mem_ready = 1'b1; B_taken = tk;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (ctl !== e[i]) begin n_fail++; $display("FAIL branch%0d cyc%0d got %b exp %b", tk, i, ctl, e[i]); end
            @(negedge clk);
        end
        B_taken = 1'b0;
        exp_ret++;
        n_tests++;
        if (instret !== exp_ret) begin n_fail++; $display("FAIL branch_instret got %0d exp %0d", instret, exp_ret); end
    endtask

    task automatic test_jalr;
        logic [18:0] e [5];
        e = '{19'b1_0_0_1_1_0_10_00_10_00_000_0_0, 19'b0_0_0_0_0_0_00_01_01_00_000_0_0,
              19'b0_0_0_0_0_0_00_10_01_00_000_0_0, 19'b0_0_0_0_1_0_00_01_10_00_000_0_0,
              19'b0_0_0_0_0_1_00_00_00_00_000_0_0};
        opcode = 7'b1100111; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (ctl !== e[i]) begin n_fail++; $display("FAIL jalr cyc%0d got %b exp %b", i, ctl, e[i]); end
            @(negedge clk);
        end
        exp_ret++;
        n_tests++;
        if (instret !== exp_ret) begin n_fail++; $display("FAIL jalr_instret got %0d exp %0d", instret, exp_ret); end
    endtask

    task automatic test_jal;
        logic [18:0] e [4];
        e = '{19'b1_0_0_1_1_0_10_00_10_00_011_0_0, 19'b0_0_0_0_0_0_00_01_01_00_011_0_0,
              19'b0_0_0_0_1_0_00_01_10_00_011_0_0, 19'b0_0_0_0_0_1_00_00_00_00_011_0_0};
        opcode = 7'b1101111; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (ctl !== e[i]) begin n_fail++; $display("FAIL jal cyc%0d got %b exp %b", i, ctl, e[i]); end
            @(negedge clk);
        end
        exp_ret++;
        n_tests++;
        if (instret !== exp_ret) begin n_fail++; $display("FAIL jal_instret got %0d exp %0d", instret, exp_ret); end
    endtask

    task automatic test_illegal;
        logic [18:0] ev;
        opcode = 7'b1111111; mem_ready = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 12; i++) begin
            ev = (i == 0) ? 19'b1_0_0_1_1_0_10_00_10_00_000_0_0 :
                 (i == 1) ? 19'b0_0_0_0_0_0_00_01_01_00_000_0_0 : 19'b1;
            #1;
            n_tests++;
            if (ctl !== ev) begin n_fail++; $display("FAIL trap cyc%0d got %b exp %b", i, ctl, ev); end
            @(negedge clk);
        end
        n_tests++;
        if (instret !== exp_ret) begin n_fail++; $display("FAIL trap_instret got %0d exp %0d", instret, exp_ret); end
        reset = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 19'b0) begin n_fail++; $display("FAIL trap_reset got %b exp %b", ctl, 19'b0); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_ret = 0;
        n_tests++;
        if (ctl !== 19'b1_0_0_1_1_0_10_00_10_00_000_0_0 || instret !== exp_ret) begin
            n_fail++; $display("FAIL trap_clear got %b/%0d exp %b/%0d", ctl, instret, 19'b1_0_0_1_1_0_10_00_10_00_000_0_0, exp_ret);
        end
        @(negedge clk);
        opcode = 7'b0110011;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        exp_ret++;
`else
        for (int i = 0; i < 2; i++) begin
            ev = (i == 0) ? 19'b1_0_0_1_1_0_10_00_10_00_000_0_0 : 19'b0_0_0_0_0_0_00_01_01_00_000_0_0;
            #1;
            n_tests++;
            if (ctl !== ev) begin n_fail++; $display("FAIL nop cyc%0d got %b exp %b", i, ctl, ev); end
            @(negedge clk);
        end
        exp_ret++;
`endif
        n_tests++;
        if (instret !== exp_ret) begin n_fail++; $display("FAIL illegal_instret got %0d exp %0d", instret, exp_ret); end
    endtask

    task automatic test_reset_mid;
        logic [18:0] e [5];
        logic        mr [5];
        e = '{19'b1_0_0_1_1_0_10_00_10_00_001_0_0, 19'b0_0_0_0_0_0_00_01_01_00_001_0_0,
              19'b0_0_0_0_0_0_00_10_01_00_001_0_0, 19'b1_1_1_0_0_0_00_00_00_00_001_0_0,
              19'b1_1_1_0_0_0_00_00_00_00_001_0_0};
        mr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        opcode = 7'b0100011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            #1;
            n_tests++;
            if (ctl !== e[i]) begin n_fail++; $display("FAIL midrst cyc%0d got %b exp %b", i, ctl, e[i]); end
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 19'b0) begin n_fail++; $display("FAIL midrst_force got %b exp %b", ctl, 19'b0); end
        @(negedge clk);
        n_tests++;
        if (ctl !== 19'b0 || instret !== 32'd0) begin
            n_fail++; $display("FAIL midrst_hold got %b/%0d exp %b/0", ctl, instret, 19'b0);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (ctl !== 19'b1_0_0_0_0_0_10_00_10_00_001_0_0) begin
            n_fail++; $display("FAIL midrst_fetch got %b exp %b", ctl, 19'b1_0_0_0_0_0_10_00_10_00_001_0_0);
        end
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_load;
        test_store;
        test_branch(1'b1);
        test_branch(1'b0);
        test_jalr;
        test_jal;
        test_illegal;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
